// File: rtl/sine_layer_pkg.sv
// Shared constants for the sine overlay: quarter-wave table, speed width and mode encoding.
package sine_layer_pkg;

  localparam int unsigned SPEED_W = 4;

  typedef enum logic {
    ModeLine = 1'b0,
    ModeFill = 1'b1
  } mode_e;

  // T[i] = round(64 * sin(pi * i / 64)), i = 0..32
  localparam logic [6:0] T [33] = '{
    7'd0,  7'd3,  7'd6,  7'd9,  7'd12, 7'd16, 7'd19, 7'd22,
    7'd24, 7'd27, 7'd30, 7'd33, 7'd36, 7'd38, 7'd41, 7'd43,
    7'd45, 7'd47, 7'd49, 7'd51, 7'd53, 7'd55, 7'd56, 7'd58,
    7'd59, 7'd60, 7'd61, 7'd62, 7'd63, 7'd63, 7'd64, 7'd64,
    7'd64
  };

endpackage

// File: rtl/sine_height.sv
// Combinational wave height: quarter-wave lookup scaled by the amplitude, rounded to pixels.
module sine_height
  import sine_layer_pkg::*;
#(
  parameter int unsigned AMP = 12
) (
  input  logic [5:0] idx,
  output logic [6:0] h
);

  logic [12:0] prod;

  always_comb begin
    prod = 13'(AMP) * 13'(T[idx]) + 13'd32;
    h    = 7'(prod >> 6);
  end

endmodule

// File: rtl/sine_scroll_layer.sv
// Animated sine-wave overlay: per-frame phase scroll, two-stage pixel pipeline to overlay_active.
module sine_scroll_layer
  import sine_layer_pkg::*;
#(
  parameter int unsigned X0          = 374,
  parameter int unsigned Y0          = 96,
  parameter int unsigned PERIOD_LOG2 = 7,
  parameter int unsigned SPAN        = 256,
  parameter int unsigned AMP         = 12,
  parameter int unsigned THICK       = 0
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [9:0]             x,
  input  logic [9:0]             y,
  input  logic                   frame_start,
  input  logic                   enable,
  input  logic [SPEED_W-1:0]     speed,
  input  logic                   mode,
  output logic                   overlay_active,
  output logic [PERIOD_LOG2-1:0] phase
);

  localparam int unsigned       PL   = PERIOD_LOG2;
  localparam int unsigned       QL   = 1 << (PL - 2);
  localparam logic signed [11:0] YC  = 12'(Y0 + AMP);
  localparam logic [9:0]        YMAX = 10'(Y0 + 2 * AMP);

  logic [PL-1:0]       phase_d, phase_q;
  logic [9:0]          off_x;
  logic [PL-1:0]       p;
  logic [PL-3:0]       pos;
  logic [5:0]          idx_d, idx_q;
  logic [1:0]          q_d, q_q;
  logic                win_d, win_q;
  logic [9:0]          y_q;
  logic [6:0]          h;
  logic signed [11:0]  s, row, yv, diff;
  logic                line_hit, fill_hit;
  logic                active_d, active_q;

  always_comb begin
    phase_d = phase_q;
    if (frame_start && enable) begin
      phase_d = phase_q + PL'($signed(speed));
    end
  end

  // Stage 1: pixel phase, quadrant fold and band window.
  always_comb begin
    off_x = x - 10'(X0);
    p     = off_x[PL-1:0] + phase_q;
    q_d   = p[PL-1:PL-2];
    pos   = p[PL-3:0];
    idx_d = (q_d[0] ? (6'(QL) - 6'(pos)) : 6'(pos)) << (7 - PL);
    win_d = (off_x < 10'(SPAN)) && (y >= 10'(Y0)) && (y <= YMAX);
  end

  sine_height #(
    .AMP (AMP)
  ) u_height (
    .idx (idx_q),
    .h   (h)
  );

  // Stage 2: compare the beam row against the curve row yc - s.
  always_comb begin
    s = $signed({5'b0, h});
    if (q_q[1]) begin
      s = -s;
    end
    row  = YC - s;
    yv   = $signed({2'b0, y_q});
    diff = yv - row;
    if (diff < 0) begin
      diff = -diff;
    end
    line_hit = diff <= $signed(12'(THICK));
    fill_hit = ((yv <= YC) && (yv >= row)) || ((yv >= YC) && (yv <= row));
    active_d = win_q && ((mode == ModeFill) ? fill_hit : line_hit);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      phase_q  <= '0;
      idx_q    <= '0;
      q_q      <= '0;
      win_q    <= 1'b0;
      y_q      <= '0;
      active_q <= 1'b0;
    end else begin
      phase_q  <= phase_d;
      idx_q    <= idx_d;
      q_q      <= q_d;
      win_q    <= win_d;
      y_q      <= y;
      active_q <= active_d;
    end
  end

  assign overlay_active = active_q;
  assign phase          = phase_q;

endmodule

// File: doc/sine_scroll_layer.md
# sine_scroll_layer

Parametrised, animated sine-wave overlay for the VGA pixel pipeline. Given the current beam position, it asserts `overlay_active` for pixels on, or under, a sine curve. The curve's period, amplitude, position, span and thickness are set by parameters. A per-frame phase accumulator scrolls the wave horizontally at a programmable signed speed. The block sits between the sync generator and the colour mux, alongside the other overlay layers, and drives its output through a two-stage registered pixel pipeline.

## Interface
- `X0`, 374: left edge of the wave band, in pixels.
- `Y0`, 96: top of the band. The centre line is `yc = Y0 + AMP`.
- `PERIOD_LOG2`, 7: wave period is 2^PERIOD_LOG2 pixels. Legal range 4..7.
- `SPAN`, 256: visible band width in pixels, 1..512.
- `AMP`, 12: peak height in pixels, 1..63.
- `THICK`, 0: half-thickness of the line in line mode, 0..7.
- `clk`  in  1: pixel clock.
- `rst`  in  1: synchronous, active-high reset.
- `x`  in  10: current beam column.
- `y`  in  10: current beam row.
- `frame_start`  in  1: one-cycle pulse, asserted in vertical blanking.
- `enable`  in  1: when 0, the phase is frozen.
- `speed`  in  4: signed two's complement phase step per frame, in pixels.
- `mode`  in  1: 0 = line, 1 = filled area between the curve and the centre line.
- `overlay_active`  out  1: registered pixel-on flag.
- `phase`  out  PERIOD_LOG2: current phase accumulator value.

## Operation
- Phase accumulator:
  - On `frame_start && enable`: `phase <= phase + sext(speed)`, modulo 2^PERIOD_LOG2.
  - Otherwise it holds its value.
  - A change to `speed` takes effect at the next `frame_start`.
- Pixel phase:
  - `off_x = x - X0` (10-bit unsigned wrap).
  - `p = off_x[PL-1:0] + phase` (PL = PERIOD_LOG2).
- Quadrant decode:
  - `q = p[PL-1:PL-2]`, `pos = p[PL-3:0]`, `QL = 2^(PL-2)`.
  - `idx = (q[0] ? QL - pos : pos) << (7 - PL)`, giving range 0..32.
- Quarter-wave table: `T[i] = round(64*sin(pi*i/64))` for i = 0..32, values 0..64, 7 bits.
- Height: `h = (AMP*T[idx] + 32) >> 6` (13-bit product). Signed height `s = q[1] ? -h : h`.
- Curve row: `yc - s`. Positive `s` is above the centre line.
- Window: `off_x < SPAN` and `Y0 <= y <= Y0 + 2*AMP`. Outside the window the output is 0. Because `off_x` wraps, `x < X0` always falls outside.
- Line mode: active when `|y - (yc - s)| <= THICK`.
- Fill mode: active when `y` lies between `yc` and `yc - s`, inclusive of both ends.

## Timing
- Reset values: `phase = 0`, `overlay_active = 0`, all pipeline registers 0.
- Latency is 2 clocks from `x`/`y` to `overlay_active`, with a new pixel accepted every cycle.
  - Stage 1 registers `idx`, `q`, the window flag and `y`.
  - Stage 2 registers the compare result.
- Stage 1 samples `phase` in the same cycle as the pixel. A `frame_start` affects pixels from the following cycle onward.
- Reset has priority over `frame_start`. Asserting `rst` mid-frame gives `overlay_active = 0` on the next two edges.
- Phase wrap is modular. From phase 0, `speed = -1` gives 127; from 127, `speed = +1` gives 0.
- `frame_start` while `enable = 0`: no change to the phase.

## Structure
- Package `sine_layer_pkg` holds:
  - the 33-entry quarter-wave table constant `T`;
  - the `SPEED_W = 4` constant;
  - the mode encoding.
- Sub-module `sine_height`: combinational `(idx, AMP) -> h`, containing the table lookup, multiply and round. It is instantiated once, between stage 1 and stage 2.
- All other logic (accumulator, pipeline, window and compare) is in the top module.

## Test plan
All scenarios use default parameters unless stated; compare against the output 2 clocks after the pixel is presented.
- Reset, phase 0, line mode:
  - x=374: y=108 gives 1; y=107 gives 0.
  - x=406: y=96 gives 1.
  - x=470: y=120 gives 1.
  - x=373 and x=630 give 0 at every row.
- Speed=+4, enable=1, three `frame_start` pulses: `phase`=12. At x=374, y=101 gives 1 (T[12]=36, h=7) and y=100 gives 0.
- Speed=-1 with one pulse from reset: `phase`=127. With `enable`=0, a further pulse leaves `phase`=127.
- Fill mode, phase 0, x=406: y=96..108 give 1; y=95 and y=109 give 0. At x=470, y=108..120 give 1.
- THICK=2, x=374: y=106..110 give 1; y=105 and y=111 give 0.
- Reset mid-frame with `frame_start` in the same cycle: `phase`=0 and `overlay_active` stays 0 for 2 cycles.
